// File: rtl/vram_reader_pkg.sv
// Shared types for the VRAM burst reader: bus widths, address/word types and FSM states.
package vram_reader_pkg;
   localparam int VRAM_AW = 14;
   localparam int VRAM_DW = 32;

   typedef logic [VRAM_AW-1:0] vram_addr_t;
   typedef logic [VRAM_DW-1:0] vram_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rdr_state_t;
endpackage

// File: rtl/vram_rd_fifo.sv
// Small synchronous FIFO for returned VRAM words: push, pop, occupancy count and flush.
// The head word is presented combinationally and forced to zero while empty.
module vram_rd_fifo
   import vram_reader_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_push,
   input  logic [VRAM_DW-1:0]  i_data,
   input  logic                i_pop,
   input  logic                i_flush,
   output logic [VRAM_DW-1:0]  o_data,
   output logic [CW-1:0]       o_count
);
   vram_word_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop;

   // Explicit wrap keeps non-power-of-two pointer widths (DEPTH=1) in range.
   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_flush && (r_count == CW'(DEPTH))));
endmodule

// File: rtl/vram_line_reader.sv
// Burst reader for one VRAM read port: issues credited reads, buffers returns, streams them out.
// Optional macro VRAM_READER_STRIDE_EN adds an 8-bit address stride input sampled with start.
module vram_line_reader
   import vram_reader_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 7
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [VRAM_AW-1:0]  i_base_addr,
   input  logic [CNT_W-1:0]    i_word_cnt,
`ifdef VRAM_READER_STRIDE_EN
   input  logic [7:0]          i_stride,
`endif
   input  logic                i_abort,
   output logic                o_busy,
   output logic                o_done,
   output logic [VRAM_AW-1:0]  o_vram_addr,
   output logic                o_vram_rd,
   input  logic [VRAM_DW-1:0]  i_vram_q,
   output logic [VRAM_DW-1:0]  o_out_data,
   output logic                o_out_valid,
   input  logic                i_out_ready
);
   localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = FAW + 1;
   localparam int SW  = CW + 1;

   rdr_state_t   r_state;
   rdr_state_t   w_state_next;
   vram_addr_t   r_addr;
   vram_addr_t   r_last_addr;
   vram_addr_t   w_step;
   logic [CNT_W-1:0] r_remaining;
   logic         r_discard;
   logic         r_done;
   logic [CW-1:0] w_fifo_count;
   logic [CW-1:0] w_inflight;
   logic         w_ret_valid;
   logic         w_credit;
   logic         w_issue;
   logic         w_pop;
   logic         w_last_pop;
   logic         w_start_ok;
   logic         w_zero_start;
   logic         w_abort;

   // Read-return tracking: a shift register of issued strobes aligned with i_vram_q.
   generate
      if (RD_LAT == 0) begin : g_comb_ret
         assign w_ret_valid = o_vram_rd;
         assign w_inflight  = '0;
      end else begin : g_pipe_ret
         logic [RD_LAT-1:0] r_pipe;
         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               r_pipe <= '0;
            end else begin
               r_pipe[0] <= o_vram_rd;
               for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_ret_valid = r_pipe[RD_LAT-1];
         assign w_inflight  = CW'($countones(r_pipe));
      end
   endgenerate

`ifdef VRAM_READER_STRIDE_EN
   logic [7:0] r_stride;
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)         r_stride <= '0;
      else if (w_start_ok) r_stride <= i_stride;
   end
   assign w_step = VRAM_AW'(r_stride);
`else
   assign w_step = VRAM_AW'(1);
`endif

   assign w_abort      = i_abort && (r_state != IDLE);
   assign w_start_ok   = i_start && !i_abort && (r_state == IDLE);
   assign w_zero_start = w_start_ok && (i_word_cnt == '0);
   assign w_pop        = o_out_valid && i_out_ready;
   // Pops in the current cycle do not return credit until the count updates.
   assign w_credit     = ({1'b0, w_fifo_count} + {1'b0, w_inflight}) < SW'(FIFO_DEPTH);
   assign w_issue      = (r_state == ISSUE) && !i_abort && (r_remaining != '0) && w_credit;
   assign w_last_pop   = (r_state == DRAIN) && !r_discard && (w_inflight == '0)
                         && (w_fifo_count == CW'(1)) && w_pop;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_ok && (i_word_cnt != '0)) w_state_next = ISSUE;
         end
         ISSUE: begin
            if (i_abort)                                        w_state_next = DRAIN;
            else if (w_issue && (r_remaining == CNT_W'(1)))     w_state_next = DRAIN;
         end
         DRAIN: begin
            if (r_discard) begin
               if (w_inflight == '0) w_state_next = IDLE;
            end else if (!i_abort && w_last_pop) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != IDLE);
      o_vram_rd   = w_issue;
      o_vram_addr = w_issue ? r_addr : r_last_addr;
      o_done      = r_done;
      o_out_valid = (w_fifo_count != '0);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_addr      <= '0;
         r_last_addr <= '0;
         r_remaining <= '0;
         r_discard   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_zero_start || (w_last_pop && !i_abort);
         if (w_start_ok) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_word_cnt;
         end else if (w_issue) begin
            r_addr      <= r_addr + w_step;
            r_last_addr <= r_addr;
            r_remaining <= r_remaining - CNT_W'(1);
         end
         // Aborted bursts keep busy until every outstanding return has been dropped.
         if (w_abort) begin
            r_discard   <= 1'b1;
            r_remaining <= '0;
         end else if (r_discard && (w_inflight == '0)) begin
            r_discard   <= 1'b0;
         end
      end
   end

   vram_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clock),
      .i_rst   (i_reset),
      .i_push  (w_ret_valid && !r_discard),
      .i_data  (i_vram_q),
      .i_pop   (w_pop),
      .i_flush (w_abort),
      .o_data  (o_out_data),
      .o_count (w_fifo_count)
   );
endmodule

// File: tb/tb_vram_line_reader.sv
// Self-checking bench for vram_line_reader: directed cases plus randomized bursts against a
// queue-based model of the expected address/data streams and the credit rule.
module tb_vram_line_reader;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic out_ready = 1'b0;
   logic [13:0] base_addr = '0;
   logic [CNT_W-1:0] word_cnt = '0;
`ifdef VRAM_READER_STRIDE_EN
   logic [7:0] stride = 8'd1;
`endif
   logic busy, done, vram_rd, out_valid;
   logic [13:0] vram_addr;
   logic [31:0] vram_q, out_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [31:0] exp_data_q[$];
   logic [13:0] exp_addr_q[$];
   int  outstanding = 0;
   bit  armed = 1'b0;
   bit  exp_done = 1'b0;
   logic [31:0] beat_log[$];
   int  beat_cyc[$];
   logic [13:0] iss_log[$];
   int  done_cyc[$];

   always #5 clk = ~clk;

   vram_line_reader #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_word_cnt  (word_cnt),
`ifdef VRAM_READER_STRIDE_EN
      .i_stride    (stride),
`endif
      .i_abort     (abort),
      .o_busy      (busy),
      .o_done      (done),
      .o_vram_addr (vram_addr),
      .o_vram_rd   (vram_rd),
      .i_vram_q    (vram_q),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready)
   );

   // VRAM contents: mem[k] = k * 0x01010101, returned RD_LAT cycles after the address.
   function automatic logic [31:0] mem_word(input logic [13:0] a);
      return 32'(a) * 32'h01010101;
   endfunction

   function automatic logic [13:0] model_step();
`ifdef VRAM_READER_STRIDE_EN
      return 14'(stride);
`else
      return 14'd1;
`endif
   endfunction

   logic [13:0] apipe [RD_LAT];
   always @(posedge clk) begin
      apipe[0] <= vram_addr;
      for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign vram_q = mem_word(apipe[RD_LAT-1]);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: observed %0d (cycle %0d)", name, act, cyc);
   endtask

   // Compare process: every cycle, mid-period.
   always @(negedge clk) begin
      bit done_now;
      logic [13:0] a;
      cyc++;
      if (rst) begin
         exp_data_q.delete();
         exp_addr_q.delete();
         outstanding = 0;
         armed = 1'b0;
         exp_done = 1'b0;
      end else begin
         done_now = exp_done;
         exp_done = 1'b0;
         check("done", done, done_now);
         if (done_now) check("busy_at_done", busy, 1'b0);
         if (done) done_cyc.push_back(cyc);

         if (vram_rd) begin
            iss_log.push_back(vram_addr);
            if (abort) fail_now("rd_in_abort_cycle", 1);
            else if (exp_addr_q.size() == 0) fail_now("unexpected_rd", int'(vram_addr));
            else begin
               a = exp_addr_q.pop_front();
               check("rd_addr", vram_addr, a);
            end
            check("credit_ok", outstanding < DEPTH, 1'b1);
         end else if (armed && !abort && exp_addr_q.size() > 0 && outstanding < DEPTH) begin
            fail_now("rd_stall_with_credit", outstanding);
         end

         if (exp_data_q.size() == 0) check("valid_when_nothing_due", out_valid, 1'b0);
         if (out_valid && out_ready) begin
            beat_log.push_back(out_data);
            beat_cyc.push_back(cyc);
            if (exp_data_q.size() == 0) fail_now("unexpected_beat", int'(out_data));
            else begin
               check("beat_data", out_data, exp_data_q.pop_front());
               if (exp_data_q.size() == 0 && !abort) exp_done = 1'b1;
            end
         end

         if (vram_rd) outstanding++;
         if (out_valid && out_ready) outstanding--;

         if (abort) begin
            exp_data_q.delete();
            exp_addr_q.delete();
            outstanding = 0;
            armed = 1'b0;
         end else if (start && exp_data_q.size() == 0 && exp_addr_q.size() == 0) begin
            if (word_cnt == '0) exp_done = 1'b1;
            else begin
               a = base_addr;
               for (int i = 0; i < int'(word_cnt); i++) begin
                  exp_addr_q.push_back(a);
                  exp_data_q.push_back(mem_word(a));
                  a = a + model_step();
               end
               armed = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_logs();
      beat_log.delete();
      beat_cyc.delete();
      iss_log.delete();
      done_cyc.delete();
   endtask

   task automatic do_start(input logic [13:0] b, input int n);
      base_addr = b;
      word_cnt  = CNT_W'(n);
      start     = 1'b1;
      start_cyc = cyc + 1;
      step();
      start     = 1'b0;
   endtask

   task automatic run_until_idle(input int limit, input bit toggle_ready);
      int k = 0;
      while (!(busy == 1'b0 && exp_data_q.size() == 0 && exp_addr_q.size() == 0)) begin
         if (toggle_ready) out_ready = ((k / 3) % 2) == 0;
         step();
         k++;
         if (k > limit) begin
            fail_now("idle_timeout", k);
            break;
         end
      end
      step_n(2);
      $display("burst base=%04h cnt=%0d beats=%0d issues=%0d dones=%0d",
               base_addr, word_cnt, beat_log.size(), iss_log.size(), done_cyc.size());
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_vram_rd"}, vram_rd, 1'b0);
      check({tag, "_vram_addr"}, vram_addr, 14'h0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_data"}, out_data, 32'h0);
   endtask

   task automatic basic_burst(input string tag);
      clear_logs();
      out_ready = 1'b1;
      do_start(14'h0010, 8);
      run_until_idle(200, 1'b0);
      check({tag, "_beats"}, beat_log.size(), 8);
      if (beat_log.size() == 8 && done_cyc.size() == 1) begin
         check({tag, "_first"}, beat_log[0], 32'h10101010);
         check({tag, "_last"}, beat_log[7], 32'h17171717);
         check({tag, "_consecutive"}, beat_cyc[7] - beat_cyc[0], 7);
         // First beat is visible RD_LAT+1 edges after the edge that samples start.
         check({tag, "_latency"}, beat_cyc[0] - start_cyc, RD_LAT + 2);
         check({tag, "_done_after_last"}, done_cyc[0] - beat_cyc[7], 1);
      end else begin
         fail_now({tag, "_done_count"}, done_cyc.size());
      end
   endtask

   initial begin
      int k;
      int cnt;
      int abort_at;
      step_n(2);
      check_zero_outputs("reset");
      rst = 1'b0;
      step();

      basic_burst("basic");

      clear_logs();
      do_start(14'h3FFE, 4);
      run_until_idle(200, 1'b0);
      check("wrap_issues", iss_log.size(), 4);
      if (iss_log.size() == 4 && beat_log.size() == 4) begin
         check("wrap_a0", iss_log[0], 14'h3FFE);
         check("wrap_a1", iss_log[1], 14'h3FFF);
         check("wrap_a2", iss_log[2], 14'h0000);
         check("wrap_a3", iss_log[3], 14'h0001);
         check("wrap_d0", beat_log[0], 32'h3E3E3DFE);
         check("wrap_d2", beat_log[2], 32'h00000000);
         check("wrap_d3", beat_log[3], 32'h01010101);
      end

      clear_logs();
      do_start(14'h0040, 16);
      run_until_idle(400, 1'b1);
      check("bp_beats", beat_log.size(), 16);
      out_ready = 1'b1;

      clear_logs();
      do_start(14'h0123, 0);
      run_until_idle(50, 1'b0);
      check("zero_issues", iss_log.size(), 0);
      check("zero_dones", done_cyc.size(), 1);
      if (done_cyc.size() == 1) check("zero_done_cycle", done_cyc[0] - start_cyc, 1);

      clear_logs();
      do_start(14'h0200, 6);
      step_n(2);
      do_start(14'h0300, 2);
      run_until_idle(200, 1'b0);
      check("busy_start_beats", beat_log.size(), 6);
      if (beat_log.size() == 6) check("busy_start_last", beat_log[5], 32'h07070705);

      clear_logs();
      out_ready = 1'b0;
      do_start(14'h0400, 32);
      step_n(3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_valid_next", out_valid, 1'b0);
      k = 0;
      while (busy && k < RD_LAT + 1) begin
         step();
         k++;
      end
      check("abort_busy_fall", busy, 1'b0);
      step_n(3);
      check("abort_no_done", done_cyc.size(), 0);
      clear_logs();
      out_ready = 1'b1;
      do_start(14'h0100, 2);
      run_until_idle(100, 1'b0);
      check("post_abort_beats", beat_log.size(), 2);
      if (beat_log.size() == 2) begin
         check("post_abort_d0", beat_log[0], 32'h01010100);
         check("post_abort_d1", beat_log[1], 32'h02020201);
      end

      clear_logs();
      do_start(14'h0500, 20);
      step_n(5);
      #3;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst");
      step_n(2);
      rst = 1'b0;
      step();
      basic_burst("after_rst");

      for (int b = 0; b < 25; b++) begin
         clear_logs();
         cnt = int'($urandom_range(40, 1));
         abort_at = ($urandom_range(4) == 0) ? int'($urandom_range(cnt + 3, 1)) : -1;
`ifdef VRAM_READER_STRIDE_EN
         stride = 8'($urandom_range(255));
`endif
         out_ready = ($urandom_range(3) != 0);
         do_start(14'($urandom), cnt);
         k = 0;
         while (!(busy == 1'b0 && exp_data_q.size() == 0 && exp_addr_q.size() == 0)) begin
            out_ready = ($urandom_range(3) != 0);
            abort = (k == abort_at);
            step();
            k++;
            if (k > 1000) begin
               fail_now("rand_timeout", k);
               break;
            end
         end
         abort = 1'b0;
         out_ready = 1'b1;
         step_n(2);
         $display("rand burst %0d base=%04h cnt=%0d abort_at=%0d beats=%0d",
                  b, base_addr, cnt, abort_at, beat_log.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vram_line_reader.md
Name: vram_line_reader

Overview:
- Sequential burst reader for one VRAM read port (14-bit word address, 32-bit data).
- Takes a start command (base word address, word count) and issues one VRAM read per cycle while space permits.
- Tracks reads in flight through a fixed read latency and buffers returned words in a small FIFO.
- Delivers words to a PPU/DMA-side consumer over a valid/ready stream, so the consumer never stalls the RAM pipeline.

Parameters:
- RD_LAT, 1, VRAM read latency in cycles from address to q (legal 0..3; 0 = combinational q).
- FIFO_DEPTH, 4, output buffer depth in words (power of two, >= RD_LAT+1).
- CNT_W, 7, width of word-count input (max burst 2^CNT_W - 1 words).

Ports:
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle command strobe; honoured only when busy=0.
- base_addr, in, 14, first word address, sampled on accepted start.
- word_cnt, in, CNT_W, number of words to read, sampled on accepted start.
- abort, in, 1, cancel current burst.
- busy, out, 1, burst in progress (issuing, in flight, or FIFO non-empty).
- done, out, 1, one-cycle pulse when the last word of a burst is consumed.
- vram_addr, out, 14, address to VRAM read port.
- vram_rd, out, 1, read issued this cycle.
- vram_q, in, 32, VRAM read data, valid RD_LAT cycles after vram_rd.
- out_data, out, 32, FIFO head word.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, consumer accepts when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, vram_rd=0, vram_addr=0, out_valid=0, out_data=0; FIFO pointers, in-flight pipe and counters cleared.
- States:
  - IDLE: start accepted -> ISSUE, latching addr=base_addr, remaining=word_cnt. start with word_cnt=0 -> stays IDLE, done pulses next cycle, busy stays 0.
  - ISSUE: vram_rd=1 iff remaining>0 and fifo_count+inflight < FIFO_DEPTH. Each issue: addr+1 (14-bit wrap, 16383 -> 0), remaining-1. remaining reaches 0 -> DRAIN.
  - DRAIN: waits until inflight=0 and FIFO empty -> IDLE; done pulses one cycle in that final pop cycle.
- In-flight tracking: RD_LAT-deep shift register of vram_rd; its output writes vram_q into the FIFO. RD_LAT=0 writes the same cycle as issue.
- Credit rule guarantees no FIFO overflow. A FIFO write while full is an assertion failure.
- Simultaneous push and pop in one cycle: count unchanged. Pop when empty does not occur (out_valid=0).
- Throughput: 1 word/cycle sustained with out_ready held high. First out_valid appears RD_LAT+1 cycles after the start cycle.
- start while busy=1: ignored, no state change.
- abort: highest priority over start and issue. Next cycle: issuing stops, FIFO flushed, out_valid=0, in-flight returns dropped (discard counter until pipe empty), state -> IDLE once pipe empty, no done pulse. busy stays 1 until the pipe is empty.
- vram_addr holds its last value when vram_rd=0.

Optional Feature:
- Macro VRAM_READER_STRIDE_EN.
- Defined: extra input port stride (8-bit, sampled with start); address increments by stride each issue (mod 2^14). stride=0 re-reads one word.
- Not defined: no stride port; increment is fixed at 1.

Decomposition:
- Package vram_reader_pkg:
  - VRAM_AW=14, VRAM_DW=32;
  - typedef vram_addr_t, vram_word_t;
  - enum rdr_state_t {IDLE, ISSUE, DRAIN}.
- One sub-module: vram_rd_fifo (parameterised synchronous FIFO: push, pop, count, flush).

Test Plan:
- Basic burst: RAM preloaded mem[k]=k*0x01010101. start base=0x0010, cnt=8, out_ready=1 -> 8 words 0x10101010..0x17171717 in order, on consecutive cycles. done one cycle after the last beat; busy then 0.
- Wrap: base=0x3FFE, cnt=4 -> addresses issued 0x3FFE, 0x3FFF, 0x0000, 0x0001; data matches.
- Backpressure: cnt=16, out_ready toggled 1/0 every 3 cycles; RD_LAT=2 -> no loss or duplication, at most FIFO_DEPTH words outstanding, vram_rd low whenever credit is exhausted.
- Zero count and busy-start: word_cnt=0 -> done pulse, no vram_rd. A second start during a burst -> ignored; output unchanged.
- Abort: abort on cycle 5 of a 32-word burst with out_ready=0 -> out_valid=0 next cycle, no further vram_rd, busy falls within RD_LAT+1 cycles, no done. A following start base=0x0100 cnt=2 returns mem[0x100] and mem[0x101] only.
- Reset mid-burst: reset asserted asynchronously mid-cycle -> all outputs zero immediately. After release, a new burst behaves as in the basic-burst case.
